// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the ALU sequencer (master) and the
// multi-cycle divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_op, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned
// per operation, with divide-by-zero and signed-overflow flags.
module seq_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] mag_d;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic             ovf;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand magnitudes and the trial subtraction for the current iteration.
  always_comb begin
    mag_a   = (bus.signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    mag_b   = (bus.signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    shifted = {prem, work_q[WIDTH-1]};
    trial   = shifted - {1'b0, mag_d};
  end

  assign bus.busy = (state != IDLE);

  // On a zero divisor work_q keeps the raw dividend so FIX can return it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      prem            <= '0;
      work_q          <= '0;
      mag_d           <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz              <= 1'b0;
      ovf             <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q  <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r  <= bus.signed_op & bus.dividend[WIDTH-1];
            dz     <= (bus.divisor == '0);
            ovf    <= bus.signed_op && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
            mag_d  <= mag_b;
            prem   <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            work_q <= (bus.divisor == '0) ? bus.dividend : mag_a;
            state  <= (bus.divisor == '0) ? FIX : RUN;
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            prem   <= trial[WIDTH-1:0];
            work_q <= {work_q[WIDTH-2:0], 1'b1};
          end else begin
            prem   <= shifted[WIDTH-1:0];
            work_q <= {work_q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            bus.quotient    <= '1;
            bus.remainder   <= work_q;
            bus.div_by_zero <= 1'b1;
            bus.overflow    <= 1'b0;
          end else if (ovf) begin
            bus.quotient    <= MIN_VAL;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b1;
          end else begin
            bus.quotient    <= neg_q ? -work_q : work_q;
            bus.remainder   <= neg_r ? -prem : prem;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
          end
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a request at the falling edge, return 1 time unit after the accept edge.
  task automatic applyStimulus(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    if (w8) begin
      bus8.start = 1'b1; bus8.signed_op = s; bus8.dividend = a[7:0]; bus8.divisor = b[7:0];
    end else begin
      bus32.start = 1'b1; bus32.signed_op = s; bus32.dividend = a; bus32.divisor = b;
    end
    @(posedge clk);
    #1;
    bus8.start = 1'b0; bus32.start = 1'b0;
    bus8.dividend = ~a[7:0]; bus8.divisor = ~b[7:0];
    bus32.dividend = ~a; bus32.divisor = ~b;
  endtask

  task automatic waitDone(input bit w8, output int n, output int busyN);
    logic d;
    n = 0;
    busyN = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      d = w8 ? bus8.done : bus32.done;
      if (!d && (w8 ? bus8.busy : bus32.busy)) busyN++;
    end
  endtask

  function automatic logic [17:0] refModel8(input bit s, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, qi, ri;
    if (b == 8'd0) return {1'b0, 1'b1, a, 8'hFF};
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) return {1'b1, 1'b0, 8'h00, 8'h80};
      qi = sa / sb;
      ri = sa % sb;
      return {2'b00, 8'(ri), 8'(qi)};
    end
    return {2'b00, a % b, a / b};
  endfunction

  initial begin
    int n, bn, pulses;
    bit s;
    logic [7:0] a8, b8;
    logic [17:0] exp8;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus32.start = 1'b0; bus32.signed_op = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
    bus8.start  = 1'b0; bus8.signed_op  = 1'b0; bus8.dividend  = '0; bus8.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state32", {bus32.busy, bus32.done, bus32.div_by_zero, bus32.overflow, bus32.quotient, bus32.remainder}, 68'd0);
    checkOutput("reset_state8", {bus8.busy, bus8.done, bus8.div_by_zero, bus8.overflow, bus8.quotient, bus8.remainder}, 20'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] unsigned 100 / 7");
    applyStimulus(0, 0, 32'd100, 32'd7);
    checkOutput("busy_after_accept", bus32.busy, 1'b1);
    waitDone(0, n, bn);
    checkOutput("u100_7_latency", n, 33);
    checkOutput("u100_7_busy_cycles", bn + 1, 33);
    checkOutput("u100_7_busy_on_done", bus32.busy, 1'b0);
    checkOutput("u100_7_q", bus32.quotient, 32'd14);
    checkOutput("u100_7_r", bus32.remainder, 32'd2);
    checkOutput("u100_7_flags", {bus32.div_by_zero, bus32.overflow}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", bus32.done, 1'b0);
    checkOutput("u100_7_q_held", bus32.quotient, 32'd14);

    $display("[TB] signed cases");
    applyStimulus(0, 1, 32'hFFFFFF9C, 32'd7);
    waitDone(0, n, bn);
    checkOutput("s_m100_7_q", bus32.quotient, 32'hFFFFFFF2);
    checkOutput("s_m100_7_r", bus32.remainder, 32'hFFFFFFFE);
    applyStimulus(0, 1, 32'd100, 32'hFFFFFFF9);
    waitDone(0, n, bn);
    checkOutput("s_100_m7_q", bus32.quotient, 32'hFFFFFFF2);
    checkOutput("s_100_m7_r", bus32.remainder, 32'd2);
    applyStimulus(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9);
    waitDone(0, n, bn);
    checkOutput("s_m100_m7_q", bus32.quotient, 32'd14);
    checkOutput("s_m100_m7_r", bus32.remainder, 32'hFFFFFFFE);
    checkOutput("s_m100_m7_flags", {bus32.div_by_zero, bus32.overflow}, 2'b00);

    $display("[TB] divide by zero");
    applyStimulus(0, 0, 32'h12345678, 32'd0);
    waitDone(0, n, bn);
    checkOutput("dz_latency", n, 1);
    checkOutput("dz_q", bus32.quotient, 32'hFFFFFFFF);
    checkOutput("dz_r", bus32.remainder, 32'h12345678);
    checkOutput("dz_flags", {bus32.div_by_zero, bus32.overflow}, 2'b10);

    $display("[TB] MIN / -1");
    applyStimulus(0, 1, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, n, bn);
    checkOutput("ovf_q", bus32.quotient, 32'h80000000);
    checkOutput("ovf_r", bus32.remainder, 32'd0);
    checkOutput("ovf_flags", {bus32.div_by_zero, bus32.overflow}, 2'b01);
    applyStimulus(0, 0, 32'h80000000, 32'hFFFFFFFF);
    waitDone(0, n, bn);
    checkOutput("u_min_q", bus32.quotient, 32'd0);
    checkOutput("u_min_r", bus32.remainder, 32'h80000000);
    checkOutput("u_min_flags", {bus32.div_by_zero, bus32.overflow}, 2'b00);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b1; bus32.dividend = 32'd1000; bus32.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    waitDone(0, n, bn);
    checkOutput("ignored_latency", n + 5, 33);
    checkOutput("ignored_q", bus32.quotient, 32'd14);
    checkOutput("ignored_r", bus32.remainder, 32'd2);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done || bus32.busy) pulses++;
    end
    checkOutput("ignored_no_second_op", pulses, 0);

    $display("[TB] back-to-back");
    applyStimulus(0, 0, 32'd100, 32'd7);
    waitDone(0, n, bn);
    bus32.start = 1'b1; bus32.signed_op = 1'b0; bus32.dividend = 32'd1000; bus32.divisor = 32'd3;
    checkOutput("b2b_first_q", bus32.quotient, 32'd14);
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    checkOutput("b2b_accepted", bus32.busy, 1'b1);
    waitDone(0, n, bn);
    checkOutput("b2b_period", n + 1, 34);
    checkOutput("b2b_q", bus32.quotient, 32'd333);
    checkOutput("b2b_r", bus32.remainder, 32'd1);

    $display("[TB] reset mid-run");
    applyStimulus(0, 0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy", bus32.busy, 1'b0);
    checkOutput("rst_mid_outputs", {bus32.done, bus32.div_by_zero, bus32.overflow, bus32.quotient, bus32.remainder}, 67'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done) pulses++;
    end
    checkOutput("rst_mid_no_done", pulses, 0);

    $display("[TB] WIDTH=8 directed");
    applyStimulus(1, 0, 32'd255, 32'd16);
    waitDone(1, n, bn);
    checkOutput("w8_latency", n, 9);
    checkOutput("w8_q", bus8.quotient, 8'd15);
    checkOutput("w8_r", bus8.remainder, 8'd15);

    $display("[TB] WIDTH=8 random sweep");
    for (int i = 0; i < 1000; i++) begin
      s  = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        a8 = 8'h80;
        b8 = 8'hFF;
      end
      exp8 = refModel8(s, a8, b8);
      applyStimulus(1, s, {24'd0, a8}, {24'd0, b8});
      waitDone(1, n, bn);
      checkOutput($sformatf("rand%0d_s%0d_%0h_%0h", i, s, a8, b8),
                  {8'(n), bus8.overflow, bus8.div_by_zero, bus8.remainder, bus8.quotient},
                  {(b8 == 8'd0) ? 8'd1 : 8'd9, exp8});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
